// File: rtl/div_ctrl_if.sv
// div_ctrl_if: handshake bundle between the divide controller, its request source,
// the iterative divider and writeback. master = controller side, slave = environment side.
`default_nettype none

interface div_ctrl_if;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  req_rd;
   logic        div_in_valid;
   logic        div_in_ready;
   logic        div_sign;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        div_flush;
   logic        div_out_valid;
   logic        div_out_ready;
   logic [31:0] div_quot;
   logic [31:0] div_rem;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;

   modport master (
      input  flush, req_valid, req_op, req_a, req_b, req_rd,
             div_in_ready, div_out_valid, div_quot, div_rem, wb_ready,
      output req_ready, div_in_valid, div_sign, div_a, div_b, div_flush,
             div_out_ready, wb_valid, wb_data, wb_rd
   );

   modport slave (
      output flush, req_valid, req_op, req_a, req_b, req_rd,
             div_in_ready, div_out_valid, div_quot, div_rem, wb_ready,
      input  req_ready, div_in_valid, div_sign, div_a, div_b, div_flush,
             div_out_ready, wb_valid, wb_data, wb_rd
   );
endinterface

`default_nettype wire

// File: rtl/div_ctrl.sv
// div_ctrl: RV32M DIV/DIVU/REM/REMU execute-stage controller. Resolves divide-by-zero and
// signed overflow locally, otherwise issues to an external divider; Rev 1.0.
`default_nettype none

module div_ctrl (
   input  logic       clk,
   input  logic       rst,
   div_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [31:0] C_ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [31:0] C_INT_MIN  = 32'h8000_0000;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [4:0]  r_rd;
   logic [31:0] r_wb_data;
   logic        r_st_idle;
   logic        r_st_issue;
   logic        r_st_wait;
   logic        r_st_done;

   logic        w_accept;
   logic        w_req_signed;
   logic        w_div_zero;
   logic        w_overflow;
   logic        w_special;
   logic [31:0] w_special_data;
   logic        w_issue_hs;
   logic        w_result_hs;
   logic        w_wb_hs;

   assign bus.req_ready     = r_st_idle & ~bus.flush;
   assign bus.div_in_valid  = r_st_issue & ~bus.flush;
   assign bus.div_out_ready = r_st_wait;
   assign bus.wb_valid      = r_st_done;
   assign bus.div_flush     = bus.flush;
   assign bus.div_sign      = ~r_op[0];
   assign bus.div_a         = r_a;
   assign bus.div_b         = r_b;
   assign bus.wb_data       = r_wb_data;
   assign bus.wb_rd         = r_rd;

   assign w_accept     = bus.req_valid & bus.req_ready;
   assign w_req_signed = ~bus.req_op[0];
   assign w_div_zero   = (bus.req_b == 32'd0);
   assign w_overflow   = w_req_signed & (bus.req_a == C_INT_MIN) & (bus.req_b == C_ALL_ONES);
   assign w_special    = w_div_zero | w_overflow;

   // Divide-by-zero takes precedence: quot=all ones, rem=dividend; overflow gives INT_MIN / 0.
   always_comb begin
      w_special_data = 32'd0;
      if (bus.req_op[1]) begin
         w_special_data = w_div_zero ? bus.req_a : 32'd0;
      end else begin
         w_special_data = w_div_zero ? C_ALL_ONES : C_INT_MIN;
      end
   end

   assign w_issue_hs  = bus.div_in_valid & bus.div_in_ready;
   assign w_result_hs = bus.div_out_valid & bus.div_out_ready;
   assign w_wb_hs     = bus.wb_valid & bus.wb_ready;

   always_comb begin
      w_state_nxt = r_state;
      if (bus.flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  w_state_nxt = w_special ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_issue_hs) begin
                  w_state_nxt = S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_result_hs) begin
                  w_state_nxt = S_DONE;
               end
            end
            S_DONE: begin
               if (w_wb_hs) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // State flags are registered alongside the state so handshake outputs come straight from flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_st_idle  <= 1'b1;
         r_st_issue <= 1'b0;
         r_st_wait  <= 1'b0;
         r_st_done  <= 1'b0;
         r_op       <= 2'd0;
         r_a        <= 32'd0;
         r_b        <= 32'd0;
         r_rd       <= 5'd0;
         r_wb_data  <= 32'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_st_idle  <= (w_state_nxt == S_IDLE);
         r_st_issue <= (w_state_nxt == S_ISSUE);
         r_st_wait  <= (w_state_nxt == S_WAIT);
         r_st_done  <= (w_state_nxt == S_DONE);

         if (w_accept) begin
            r_op <= bus.req_op;
            r_a  <= bus.req_a;
            r_b  <= bus.req_b;
            r_rd <= bus.req_rd;
            if (w_special) begin
               r_wb_data <= w_special_data;
            end
         end else if (r_st_wait && w_result_hs && !bus.flush) begin
            r_wb_data <= r_op[1] ? bus.div_rem : bus.div_quot;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl with a behavioural divider and a 64-bit reference model.
`default_nettype none

module tb_div_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   div_ctrl_if ifc ();

   div_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.master)
   );

   // Behavioural divider: accepts when idle, answers dv_lat cycles later.
   logic        dv_busy;
   int unsigned dv_cnt;
   logic [31:0] dv_q;
   logic [31:0] dv_r;
   logic        dv_rdy_en;
   int unsigned dv_lat;

   function automatic logic [31:0] calc_q(input logic s, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 32'hFFFF_FFFF;
      if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
         return $signed(a) / $signed(b);
      end
      return a / b;
   endfunction

   function automatic logic [31:0] calc_r(input logic s, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return a;
      if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
         return $signed(a) % $signed(b);
      end
      return a % b;
   endfunction

   assign ifc.div_in_ready  = dv_rdy_en & ~dv_busy;
   assign ifc.div_out_valid = dv_busy & (dv_cnt == 0);
   assign ifc.div_quot      = dv_q;
   assign ifc.div_rem       = dv_r;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dv_busy <= 1'b0;
         dv_cnt  <= 0;
         dv_q    <= 32'd0;
         dv_r    <= 32'd0;
      end else if (ifc.div_flush) begin
         dv_busy <= 1'b0;
      end else if (!dv_busy) begin
         if (ifc.div_in_valid && ifc.div_in_ready) begin
            dv_busy <= 1'b1;
            dv_cnt  <= dv_lat;
            dv_q    <= calc_q(ifc.div_sign, ifc.div_a, ifc.div_b);
            dv_r    <= calc_r(ifc.div_sign, ifc.div_a, ifc.div_b);
         end
      end else if (dv_cnt != 0) begin
         dv_cnt <= dv_cnt - 1;
      end else if (ifc.div_out_ready) begin
         dv_busy <= 1'b0;
      end
   end

   // Reference: exact 64-bit arithmetic, truncated to 32 bits; only divide-by-zero is special.
   function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      int     ia, ib;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (op[0]) begin
         sa = longint'(a);
         sb = longint'(b);
      end else begin
         ia = a;
         ib = b;
         sa = ia;
         sb = ib;
      end
      q = sa / sb;
      r = sa - q * sb;
      return op[1] ? r[31:0] : q[31:0];
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input bit rnd_rdy,
                         input int wb_stall, input bit chk_lat, input string tag);
      logic [31:0] exp_data;
      bit          special;
      bit          issued;
      bit          done;
      int          cyc;
      exp_data = model_result(op, a, b);
      special  = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      dv_lat    = lat;
      dv_rdy_en = 1'b1;
      @(negedge clk);
      ifc.wb_ready  = 1'b0;
      ifc.req_valid = 1'b1;
      ifc.req_op    = op;
      ifc.req_a     = a;
      ifc.req_b     = b;
      ifc.req_rd    = rd;
      #1;
      checks++;
      if (ifc.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s req_ready before accept: got %b expected 1", tag, ifc.req_ready);
      end
      @(posedge clk);
      cyc = 0;
      issued = 0;
      done = 0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         ifc.req_valid = 1'b0;
         ifc.req_a     = $urandom;
         ifc.req_b     = $urandom;
         ifc.req_rd    = 5'($urandom);
         if (rnd_rdy) dv_rdy_en = 1'($urandom_range(0, 1));
         #1;
         if (ifc.div_in_valid === 1'b1) begin
            issued = 1;
            checks++;
            if ({ifc.div_sign, ifc.div_a, ifc.div_b} !== {~op[0], a, b}) begin
               errors++;
               $display("FAIL %s divider operands: got sign=%b a=%h b=%h expected sign=%b a=%h b=%h",
                        tag, ifc.div_sign, ifc.div_a, ifc.div_b, ~op[0], a, b);
            end
         end
         checks++;
         if (ifc.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s req_ready in flight: got %b expected 0", tag, ifc.req_ready);
         end
         if (ifc.wb_valid === 1'b1) done = 1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s wb_valid timeout: got none within %0d cycles expected a result", tag, cyc);
         return;
      end
      if ({ifc.wb_data, ifc.wb_rd} !== {exp_data, rd}) begin
         errors++;
         $display("FAIL %s wb result: got data=%h rd=%0d expected data=%h rd=%0d",
                  tag, ifc.wb_data, ifc.wb_rd, exp_data, rd);
      end
      checks++;
      if (issued !== !special) begin
         errors++;
         $display("FAIL %s divider issue: got issued=%0d expected %0d", tag, issued, !special);
      end
      if (chk_lat) begin
         checks++;
         if (cyc !== (special ? 1 : 3)) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", tag, cyc, special ? 1 : 3);
         end
      end
      for (int k = 0; k < wb_stall; k++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         checks++;
         if ({ifc.wb_valid, ifc.wb_data, ifc.wb_rd, ifc.req_ready} !== {1'b1, exp_data, rd, 1'b0}) begin
            errors++;
            $display("FAIL %s wb stall %0d: got v=%b data=%h rd=%0d req_ready=%b expected v=1 data=%h rd=%0d req_ready=0",
                     tag, k, ifc.wb_valid, ifc.wb_data, ifc.wb_rd, ifc.req_ready, exp_data, rd);
         end
      end
      ifc.wb_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc.wb_ready = 1'b0;
      #1;
      checks++;
      if ({ifc.wb_valid, ifc.req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL %s after wb handshake: got wb_valid=%b req_ready=%b expected 0 1",
                  tag, ifc.wb_valid, ifc.req_ready);
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      ifc.flush     = 1'b0;
      ifc.req_valid = 1'b0;
      ifc.req_op    = 2'd0;
      ifc.req_a     = 32'd0;
      ifc.req_b     = 32'd0;
      ifc.req_rd    = 5'd0;
      ifc.wb_ready  = 1'b0;
      dv_rdy_en     = 1'b1;
      dv_lat        = 0;
      #12;
      checks++;
      if ({ifc.req_ready, ifc.div_in_valid, ifc.div_out_ready, ifc.wb_valid, ifc.wb_data, ifc.wb_rd, ifc.div_flush}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset values: got rr=%b iv=%b or=%b wv=%b data=%h rd=%0d df=%b expected 1 0 0 0 0 0 0",
                  ifc.req_ready, ifc.div_in_valid, ifc.div_out_ready, ifc.wb_valid, ifc.wb_data, ifc.wb_rd, ifc.div_flush);
      end
      ifc.flush = 1'b1;
      #1;
      checks++;
      if ({ifc.div_flush, ifc.req_ready} !== 2'b10) begin
         errors++;
         $display("FAIL flush passthrough: got div_flush=%b req_ready=%b expected 1 0", ifc.div_flush, ifc.req_ready);
      end
      ifc.flush = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2,  5'd7,  0, 0, 0, 1, "div_neg7_2");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2,  5'd8,  0, 0, 0, 1, "rem_neg7_2");
      run_op(2'b11, 32'hFFFF_FFFF, 32'h10, 5'd9,  0, 0, 0, 1, "remu_ffff_10");
      run_op(2'b01, 32'hFFFF_FFFF, 32'h10, 5'd10, 0, 0, 0, 1, "divu_ffff_10");
   endtask

   task automatic test_special();
      run_op(2'b01, 32'd5, 32'd0, 5'd11, 0, 0, 0, 1, "divu_by_zero");
      run_op(2'b11, 32'd5, 32'd0, 5'd12, 0, 0, 0, 1, "remu_by_zero");
      run_op(2'b00, 32'hFFFF_FFF0, 32'd0, 5'd13, 0, 0, 0, 1, "div_by_zero");
      run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 5'd14, 0, 0, 0, 1, "rem_by_zero");
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0, 0, 0, 1, "div_overflow");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 0, 0, 0, 1, "rem_overflow");
   endtask

   task automatic test_flush();
      int  n;
      bit  bad;
      // Flush in WAIT while the divider result is valid.
      dv_lat = 0;
      dv_rdy_en = 1'b1;
      @(negedge clk);
      ifc.req_valid = 1'b1;
      ifc.req_op = 2'b00;
      ifc.req_a = 32'd100;
      ifc.req_b = 32'd7;
      ifc.req_rd = 5'd3;
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         ifc.req_valid = 1'b0;
         n++;
         #1;
      end while (!(ifc.div_out_valid && ifc.div_out_ready) && n < 20);
      ifc.flush = 1'b1;
      #1;
      checks++;
      if ({ifc.div_flush, ifc.div_out_valid, ifc.req_ready} !== 3'b110) begin
         errors++;
         $display("FAIL flush_wait cycle: got div_flush=%b out_valid=%b req_ready=%b expected 1 1 0",
                  ifc.div_flush, ifc.div_out_valid, ifc.req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      ifc.flush = 1'b0;
      #1;
      checks++;
      if ({ifc.wb_valid, ifc.req_ready, ifc.div_out_ready} !== 3'b010) begin
         errors++;
         $display("FAIL flush_wait next: got wb_valid=%b req_ready=%b out_ready=%b expected 0 1 0",
                  ifc.wb_valid, ifc.req_ready, ifc.div_out_ready);
      end
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         if (ifc.wb_valid !== 1'b0 || ifc.div_in_valid !== 1'b0) bad = 1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL flush_wait quiet: got wb_valid or div_in_valid high expected both 0");
      end
      run_op(2'b00, 32'd100, 32'd7, 5'd4, 0, 0, 0, 1, "after_flush_wait");

      // Flush in DONE drops the pending result.
      @(negedge clk);
      ifc.req_valid = 1'b1;
      ifc.req_op = 2'b01;
      ifc.req_a = 32'd9;
      ifc.req_b = 32'd0;
      @(posedge clk);
      @(negedge clk);
      ifc.req_valid = 1'b0;
      ifc.flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc.flush = 1'b0;
      #1;
      checks++;
      if ({ifc.wb_valid, ifc.req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL flush_done: got wb_valid=%b req_ready=%b expected 0 1", ifc.wb_valid, ifc.req_ready);
      end

      // A request presented during flush must not be accepted.
      @(negedge clk);
      ifc.flush = 1'b1;
      ifc.req_valid = 1'b1;
      ifc.req_op = 2'b01;
      ifc.req_b = 32'd0;
      #1;
      checks++;
      if (ifc.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle req_ready: got %b expected 0", ifc.req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      ifc.flush = 1'b0;
      ifc.req_valid = 1'b0;
      #1;
      checks++;
      if ({ifc.wb_valid, ifc.div_in_valid} !== 2'b00) begin
         errors++;
         $display("FAIL flush_idle accept: got wb_valid=%b div_in_valid=%b expected 0 0", ifc.wb_valid, ifc.div_in_valid);
      end
   endtask

   task automatic test_wb_stall();
      run_op(2'b10, 32'd1000, 32'd33, 5'd21, 0, 0, 5, 1, "wb_stall_rem");
      run_op(2'b01, 32'd77,   32'd0,  5'd22, 0, 0, 5, 1, "wb_stall_special");
   endtask

   task automatic test_async_reset();
      int n;
      run_op(2'b01, 32'd50, 32'd3, 5'd17, 0, 0, 0, 0, "pre_async");
      dv_lat = 5;
      dv_rdy_en = 1'b1;
      @(negedge clk);
      ifc.req_valid = 1'b1;
      ifc.req_op = 2'b01;
      ifc.req_a = 32'd90;
      ifc.req_b = 32'd4;
      ifc.req_rd = 5'd19;
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         ifc.req_valid = 1'b0;
         n++;
         #1;
      end while (ifc.div_out_ready !== 1'b1 && n < 20);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({ifc.req_ready, ifc.div_in_valid, ifc.div_out_ready, ifc.wb_valid, ifc.wb_data, ifc.wb_rd}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0}) begin
         errors++;
         $display("FAIL async_reset: got rr=%b iv=%b or=%b wv=%b data=%h rd=%0d expected 1 0 0 0 0 0",
                  ifc.req_ready, ifc.div_in_valid, ifc.div_out_ready, ifc.wb_valid, ifc.wb_data, ifc.wb_rd);
      end
      @(negedge clk);
      rst = 1'b0;
      run_op(2'b11, 32'd90, 32'd4, 5'd20, 0, 0, 0, 1, "after_async");
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b;
      int          sel;
      for (int i = 0; i < 40; i++) begin
         op  = 2'($urandom_range(0, 3));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) b = 32'($urandom_range(1, 17));
         else if (sel == 3) b = 32'hFFFF_FFFF;
         run_op(op, a, b, 5'($urandom), $urandom_range(0, 3), 1, $urandom_range(0, 2), 0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_special();
      test_flush();
      test_wb_stall();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
